core_regs: RTL and testbench
============================

Name: core_regs

Overview:
- Architectural register file of the 2A03 core: A, X, Y, S and the packed status register P.
- Sits directly upstream of the ALU. Drives the ALU operand buses and the incoming C/V/N/Z flags.
- Sits directly downstream of the ALU. Commits the ALU result byte and selected result flags on the clock edge.
- Also handles stack pointer stepping, PHP/PLP status packing, flag set/clear instructions, and the delayed I-flag view used for interrupt polling.

Parameters:
- SP_RESET, 8'hFD, stack pointer value after reset.
- P_UNUSED_BIT, 1'b1, value read back for P bit 5.

Ports:
- I_clock  in  1  core clock; all state updates on rising edge.
- I_reset_n  in  1  asynchronous, active-low reset.
- I_ready  in  1  RDY stall; when low, no state changes.
- I_lhs_sel  in  3  left operand: 0=A 1=X 2=Y 3=S 4=P 5=DATA 6=ZERO 7=FF.
- I_rhs_sel  in  3  right operand; same encoding as I_lhs_sel.
- I_data  in  8  memory data bus byte.
- O_lhs  out  8  left operand to ALU.
- O_rhs  out  8  right operand to ALU.
- I_result  in  8  ALU result byte.
- I_result_dst  in  3  0=none 1=A 2=X 3=Y 4=S; others are no-op.
- I_carry, I_overflow, I_sign, I_zero  in  1 each  ALU result flags.
- I_flag_mask  in  4  commit enables {N,V,Z,C}.
- I_flag_op  in  3  0=none 1=CLC 2=SEC 3=CLI 4=SEI 5=CLV 6=CLD 7=SED.
- I_plp  in  1  load P from I_data.
- I_sp_op  in  2  0=none 1=inc 2=dec 3=none.
- I_brk  in  1  B bit value for O_push_status.
- I_instr_end  in  1  last cycle of the current instruction.
- O_carry, O_overflow, O_sign, O_zero  out  1 each  current P flags, fed to the ALU.
- O_irq_mask  out  1  current I flag.
- O_decimal  out  1  current D flag (stored only; no BCD in 2A03).
- O_irq_mask_poll  out  1  I value used by the interrupt poller.
- O_push_status  out  8  {N,V,1,I_brk,D,I,Z,C}, combinational.
- O_sp  out  8  current S.

Behaviour:
- Reset (async assert, sync-free deassert):
  - A=X=Y=0, S=SP_RESET.
  - C=V=N=Z=0, D=0, I=1.
  - O_irq_mask_poll=1.
- Operand outputs:
  - O_lhs and O_rhs are purely combinational from current state and I_data.
  - No write-to-read bypass: a value written on edge k is visible on the operands from cycle k+1.
- P readback (sel=4): {N,V,P_UNUSED_BIT,1'b0,D,I,Z,C}.
- All of the following updates happen only on a rising edge with I_ready=1. With I_ready=0 every register, including O_irq_mask_poll, holds.
- Register write: I_result goes to the register chosen by I_result_dst.
- Stack pointer:
  - I_sp_op steps S by ±1, modulo 256 (00 dec -> FF, FF inc -> 00).
  - If I_result_dst=S in the same cycle, the result write wins and I_sp_op is ignored.
- Flag update priority, lowest to highest:
  1. ALU commit: each flag whose I_flag_mask bit is set takes the matching I_ flag.
  2. I_flag_op: sets or clears its one flag, overriding (1) for that flag.
  3. I_plp: loads N,V,D,I,Z,C from I_data bits 7,6,3,2,1,0 and ignores bits 5 and 4. Overrides (1) and (2).
- Interrupt poll view:
  - On an edge with I_instr_end=1, O_irq_mask_poll takes the pre-edge value of I.
  - The new I from the same edge is not used.
  - Effect: CLI/SEI/PLP executed as the final cycle delay the interrupt-mask change by one instruction.
  - Otherwise O_irq_mask_poll holds.
- Reset asserted mid-cycle forces the reset values immediately, independent of the clock and I_ready.
- Undefined select codes:
  - I_result_dst 5-7 perform no write.
  - I_sp_op=3 performs no step.
  - No X-propagation on any output.

Test Plan:
- Reset with inputs random -> A=X=Y=00, O_sp=FD, O_irq_mask=1, O_irq_mask_poll=1, O_push_status with I_brk=1 = 8'h34.
- I_result=8'h80, dst=A, mask=4'b1010, I_sign=1, I_zero=0; next cycle lhs_sel=A -> O_lhs=80, O_sign=1, O_zero=0, C and V unchanged.
- S=00, I_sp_op=dec -> O_sp=FF. Then dst=S with result=8'h42 plus sp_op=inc in the same cycle -> O_sp=42.
- I_data=8'hFF, I_plp=1, I_flag_op=CLC, mask=4'b1111 -> P readback=8'hEF, O_carry=1.
- I=1; I_flag_op=CLI with I_instr_end=1 -> O_irq_mask=0, O_irq_mask_poll stays 1. Next I_instr_end edge -> poll becomes 0.
- I_ready=0 with dst=X, sp_op=inc, flag_op=SEC, I_instr_end=1 -> X, S, C and O_irq_mask_poll all unchanged.

Source files
------------

// File: rtl/core_regs_if.sv
// core_regs_if: control, operand and flag bus between sequencer/ALU and core_regs.
// master drives the I_* controls and results; slave (core_regs) drives the O_* state views.
interface core_regs_if;
  logic       I_ready;
  logic [2:0] I_lhs_sel;
  logic [2:0] I_rhs_sel;
  logic [7:0] I_data;
  logic [7:0] O_lhs;
  logic [7:0] O_rhs;
  logic [7:0] I_result;
  logic [2:0] I_result_dst;
  logic       I_carry;
  logic       I_overflow;
  logic       I_sign;
  logic       I_zero;
  logic [3:0] I_flag_mask;
  logic [2:0] I_flag_op;
  logic       I_plp;
  logic [1:0] I_sp_op;
  logic       I_brk;
  logic       I_instr_end;
  logic       O_carry;
  logic       O_overflow;
  logic       O_sign;
  logic       O_zero;
  logic       O_irq_mask;
  logic       O_decimal;
  logic       O_irq_mask_poll;
  logic [7:0] O_push_status;
  logic [7:0] O_sp;

  modport master (
    output I_ready, I_lhs_sel, I_rhs_sel, I_data,
    output I_result, I_result_dst,
    output I_carry, I_overflow, I_sign, I_zero,
    output I_flag_mask, I_flag_op, I_plp, I_sp_op,
    output I_brk, I_instr_end,
    input  O_lhs, O_rhs,
    input  O_carry, O_overflow, O_sign, O_zero,
    input  O_irq_mask, O_decimal, O_irq_mask_poll,
    input  O_push_status, O_sp
  );

  modport slave (
    input  I_ready, I_lhs_sel, I_rhs_sel, I_data,
    input  I_result, I_result_dst,
    input  I_carry, I_overflow, I_sign, I_zero,
    input  I_flag_mask, I_flag_op, I_plp, I_sp_op,
    input  I_brk, I_instr_end,
    output O_lhs, O_rhs,
    output O_carry, O_overflow, O_sign, O_zero,
    output O_irq_mask, O_decimal, O_irq_mask_poll,
    output O_push_status, O_sp
  );
endinterface

// File: rtl/core_regs.sv
// core_regs: 2A03 architectural registers A/X/Y/S/P, operand muxes, flag commit, I poll view.
// Ports: I_clock, I_reset_n (async active-low), bus (core_regs_if.slave).
module core_regs #(
  parameter logic [7:0] SP_RESET     = 8'hFD,
  parameter logic       P_UNUSED_BIT = 1'b1
) (
  input logic        I_clock,
  input logic        I_reset_n,
  core_regs_if.slave bus
);

  logic [7:0] a_q, a_d, x_q, x_d;
  logic [7:0] y_q, y_d, s_q, s_d;
  logic       c_q, c_d, v_q, v_d;
  logic       n_q, n_d, z_q, z_d;
  logic       d_q, d_d, i_q, i_d;
  logic       poll_q, poll_d;
  logic [7:0] p_rd;

  assign p_rd = {n_q, v_q, P_UNUSED_BIT, 1'b0,
                 d_q, i_q, z_q, c_q};

  function automatic logic [7:0] opnd(
    input logic [2:0] sel,
    input logic [7:0] a, x, y, s, p, dat
  );
    case (sel)
      3'd0:    opnd = a;
      3'd1:    opnd = x;
      3'd2:    opnd = y;
      3'd3:    opnd = s;
      3'd4:    opnd = p;
      3'd5:    opnd = dat;
      3'd6:    opnd = 8'h00;
      default: opnd = 8'hFF;
    endcase
  endfunction

  assign bus.O_lhs = opnd(bus.I_lhs_sel, a_q, x_q,
                          y_q, s_q, p_rd, bus.I_data);
  assign bus.O_rhs = opnd(bus.I_rhs_sel, a_q, x_q,
                          y_q, s_q, p_rd, bus.I_data);

  assign bus.O_carry         = c_q;
  assign bus.O_overflow      = v_q;
  assign bus.O_sign          = n_q;
  assign bus.O_zero          = z_q;
  assign bus.O_irq_mask      = i_q;
  assign bus.O_decimal       = d_q;
  assign bus.O_irq_mask_poll = poll_q;
  assign bus.O_sp            = s_q;
  assign bus.O_push_status   = {n_q, v_q, 1'b1, bus.I_brk,
                                d_q, i_q, z_q, c_q};

  always_comb begin
    a_d    = a_q;
    x_d    = x_q;
    y_d    = y_q;
    s_d    = s_q;
    c_d    = c_q;
    v_d    = v_q;
    n_d    = n_q;
    z_d    = z_q;
    d_d    = d_q;
    i_d    = i_q;
    poll_d = poll_q;
    if (bus.I_ready) begin
      // A result write to S takes precedence over stepping.
      if (bus.I_result_dst == 3'd4) begin
        s_d = bus.I_result;
      end else if (bus.I_sp_op == 2'd1) begin
        s_d = s_q + 8'd1;
      end else if (bus.I_sp_op == 2'd2) begin
        s_d = s_q - 8'd1;
      end
      case (bus.I_result_dst)
        3'd1:    a_d = bus.I_result;
        3'd2:    x_d = bus.I_result;
        3'd3:    y_d = bus.I_result;
        default: ;
      endcase
      if (bus.I_flag_mask[3]) n_d = bus.I_sign;
      if (bus.I_flag_mask[2]) v_d = bus.I_overflow;
      if (bus.I_flag_mask[1]) z_d = bus.I_zero;
      if (bus.I_flag_mask[0]) c_d = bus.I_carry;
      case (bus.I_flag_op)
        3'd1:    c_d = 1'b0;
        3'd2:    c_d = 1'b1;
        3'd3:    i_d = 1'b0;
        3'd4:    i_d = 1'b1;
        3'd5:    v_d = 1'b0;
        3'd6:    d_d = 1'b0;
        3'd7:    d_d = 1'b1;
        default: ;
      endcase
      if (bus.I_plp) begin
        n_d = bus.I_data[7];
        v_d = bus.I_data[6];
        d_d = bus.I_data[3];
        i_d = bus.I_data[2];
        z_d = bus.I_data[1];
        c_d = bus.I_data[0];
      end
      // Poller sees I as it was before this instruction's last edge.
      if (bus.I_instr_end) poll_d = i_q;
    end
  end

  always_ff @(posedge I_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      a_q    <= 8'h00;
      x_q    <= 8'h00;
      y_q    <= 8'h00;
      s_q    <= SP_RESET;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      n_q    <= 1'b0;
      z_q    <= 1'b0;
      d_q    <= 1'b0;
      i_q    <= 1'b1;
      poll_q <= 1'b1;
    end else begin
      a_q    <= a_d;
      x_q    <= x_d;
      y_q    <= y_d;
      s_q    <= s_d;
      c_q    <= c_d;
      v_q    <= v_d;
      n_q    <= n_d;
      z_q    <= z_d;
      d_q    <= d_d;
      i_q    <= i_d;
      poll_q <= poll_d;
    end
  end

endmodule

// File: tb/tb_core_regs.sv
// tb_core_regs: directed self-checking bench for core_regs.
// Drives the interface 1ns after each rising edge; checks before the next edge.
module tb_core_regs;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  core_regs_if bus ();

  core_regs dut (
    .I_clock   (clk),
    .I_reset_n (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h",
               tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.I_ready      = 1'b1;
    bus.I_lhs_sel    = 3'd0;
    bus.I_rhs_sel    = 3'd0;
    bus.I_data       = 8'h00;
    bus.I_result     = 8'h00;
    bus.I_result_dst = 3'd0;
    bus.I_carry      = 1'b0;
    bus.I_overflow   = 1'b0;
    bus.I_sign       = 1'b0;
    bus.I_zero       = 1'b0;
    bus.I_flag_mask  = 4'd0;
    bus.I_flag_op    = 3'd0;
    bus.I_plp        = 1'b0;
    bus.I_sp_op      = 2'd0;
    bus.I_brk        = 1'b0;
    bus.I_instr_end  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [2:0] dst,
                    input logic [7:0] val);
    bus.I_result_dst = dst;
    bus.I_result     = val;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    bus.I_ready      = 1'b1;
    bus.I_data       = 8'($urandom);
    bus.I_result     = 8'($urandom);
    bus.I_result_dst = 3'($urandom);
    bus.I_flag_mask  = 4'hF;
    bus.I_flag_op    = 3'($urandom);
    bus.I_plp        = 1'b1;
    bus.I_sp_op      = 2'($urandom);
    bus.I_instr_end  = 1'b1;
    bus.I_carry      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    idle();
    bus.I_brk = 1'b1;
    #1;
    chk("rst_a", bus.O_lhs, 8'h00);
    bus.I_lhs_sel = 3'd1;
    bus.I_rhs_sel = 3'd2;
    #1;
    chk("rst_x", bus.O_lhs, 8'h00);
    chk("rst_y", bus.O_rhs, 8'h00);
    chk("rst_sp", bus.O_sp, 8'hFD);
    chk("rst_i", 8'(bus.O_irq_mask), 8'h01);
    chk("rst_poll", 8'(bus.O_irq_mask_poll), 8'h01);
    chk("rst_push", bus.O_push_status, 8'h34);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    idle();

    bus.I_result_dst = 3'd1;
    bus.I_result     = 8'h80;
    bus.I_flag_mask  = 4'b1010;
    bus.I_sign       = 1'b1;
    bus.I_zero       = 1'b0;
    bus.I_carry      = 1'b1;
    bus.I_overflow   = 1'b1;
    #1;
    chk("no_bypass", bus.O_lhs, 8'h00);
    step();
    #1;
    chk("alu_a", bus.O_lhs, 8'h80);
    chk("alu_n", 8'(bus.O_sign), 8'h01);
    chk("alu_z", 8'(bus.O_zero), 8'h00);
    chk("alu_c", 8'(bus.O_carry), 8'h00);
    chk("alu_v", 8'(bus.O_overflow), 8'h00);

    wr(3'd2, 8'h11);
    wr(3'd3, 8'h22);
    wr(3'd5, 8'h99);
    bus.I_lhs_sel = 3'd1;
    bus.I_rhs_sel = 3'd2;
    #1;
    chk("wr_x", bus.O_lhs, 8'h11);
    chk("wr_y", bus.O_rhs, 8'h22);
    bus.I_lhs_sel = 3'd0;
    #1;
    chk("dst5_a", bus.O_lhs, 8'h80);
    bus.I_data    = 8'h5A;
    bus.I_lhs_sel = 3'd5;
    bus.I_rhs_sel = 3'd6;
    #1;
    chk("sel_data", bus.O_lhs, 8'h5A);
    chk("sel_zero", bus.O_rhs, 8'h00);
    bus.I_lhs_sel = 3'd7;
    #1;
    chk("sel_ff", bus.O_lhs, 8'hFF);

    wr(3'd4, 8'h00);
    bus.I_sp_op = 2'd2;
    step();
    chk("sp_dec", bus.O_sp, 8'hFF);
    bus.I_sp_op = 2'd1;
    step();
    chk("sp_inc", bus.O_sp, 8'h00);
    bus.I_sp_op = 2'd3;
    step();
    chk("sp_op3", bus.O_sp, 8'h00);
    bus.I_sp_op = 2'd1;
    wr(3'd4, 8'h42);
    bus.I_rhs_sel = 3'd3;
    #1;
    chk("sp_wr_wins", bus.O_sp, 8'h42);
    chk("sel_s", bus.O_rhs, 8'h42);

    bus.I_data      = 8'hFF;
    bus.I_plp       = 1'b1;
    bus.I_flag_op   = 3'd1;
    bus.I_flag_mask = 4'b1111;
    step();
    bus.I_lhs_sel = 3'd4;
    #1;
    chk("plp_p", bus.O_lhs, 8'hEF);
    chk("plp_c", 8'(bus.O_carry), 8'h01);
    chk("plp_d", 8'(bus.O_decimal), 8'h01);

    bus.I_flag_mask = 4'b0001;
    bus.I_carry     = 1'b1;
    bus.I_flag_op   = 3'd1;
    step();
    chk("clc_over_alu", 8'(bus.O_carry), 8'h00);
    bus.I_flag_op = 3'd5;
    step();
    chk("clv", 8'(bus.O_overflow), 8'h00);
    bus.I_flag_op = 3'd6;
    step();
    chk("cld", 8'(bus.O_decimal), 8'h00);
    bus.I_flag_op = 3'd7;
    step();
    chk("sed", 8'(bus.O_decimal), 8'h01);
    bus.I_flag_op = 3'd2;
    step();
    chk("sec", 8'(bus.O_carry), 8'h01);

    bus.I_flag_op   = 3'd3;
    bus.I_instr_end = 1'b1;
    step();
    chk("cli_i", 8'(bus.O_irq_mask), 8'h00);
    chk("cli_poll", 8'(bus.O_irq_mask_poll), 8'h01);
    bus.I_instr_end = 1'b1;
    step();
    chk("poll_lag", 8'(bus.O_irq_mask_poll), 8'h00);
    bus.I_flag_op = 3'd4;
    step();
    chk("sei_i", 8'(bus.O_irq_mask), 8'h01);
    chk("poll_hold", 8'(bus.O_irq_mask_poll), 8'h00);
    bus.I_flag_op = 3'd1;
    step();

    bus.I_ready      = 1'b0;
    bus.I_result_dst = 3'd2;
    bus.I_result     = 8'h77;
    bus.I_sp_op      = 2'd1;
    bus.I_flag_op    = 3'd2;
    bus.I_instr_end  = 1'b1;
    bus.I_plp        = 1'b1;
    bus.I_data       = 8'hFF;
    @(posedge clk);
    #1;
    bus.I_lhs_sel = 3'd1;
    #1;
    chk("rdy_x", bus.O_lhs, 8'h11);
    chk("rdy_sp", bus.O_sp, 8'h42);
    chk("rdy_c", 8'(bus.O_carry), 8'h00);
    chk("rdy_poll", 8'(bus.O_irq_mask_poll), 8'h00);
    idle();

    wr(3'd1, 8'h3C);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_a", bus.O_lhs, 8'h00);
    chk("async_sp", bus.O_sp, 8'hFD);
    chk("async_poll", 8'(bus.O_irq_mask_poll), 8'h01);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
